// File: rtl/bsc_pkg.sv
// Shared types, shifter opcodes and kind decode for the barrel shifter command sequencer.
package bsc_pkg;

  typedef enum logic [2:0] {
    K_ROL = 3'd0,
    K_ROR = 3'd1,
    K_SLL = 3'd2,
    K_SRL = 3'd3,
    K_SLA = 3'd4,
    K_SRA = 3'd5
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_HOLD = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLA  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  function automatic logic kind_defined(input logic [2:0] k);
    return k <= K_SRA;
  endfunction

  function automatic logic kind_is_rot(input logic [2:0] k);
    return (k == K_ROL) || (k == K_ROR);
  endfunction

  // Undefined kinds map to HOLD so a stray step can never corrupt the word.
  function automatic logic [3:0] kind_to_op(input logic [2:0] k);
    logic [3:0] op;
    case (k)
      K_ROL:   op = OP_ROL;
      K_ROR:   op = OP_ROR;
      K_SLL:   op = OP_SLL;
      K_SRL:   op = OP_SRL;
      K_SLA:   op = OP_SLA;
      K_SRA:   op = OP_SRA;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/barrel_shift_ctrl.sv
// Sequencer: one request -> LOAD + steps of up to 3 positions on an external barrel_shifter.
// Optional BSC_ROT_REDUCE_EN: reduce rotates modulo N and clamp shifts to N during LOAD.
//
// state  | meaning
// IDLE   | ready for a request, shifter held
// LOAD   | word pushed into the shifter, amount finalised
// STEP   | shifter op applied with s = min(rem, 3)
// DONE   | result presented until the consumer takes it
module barrel_shift_ctrl
  import bsc_pkg::*;
#(
  parameter int N  = 5,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_data,
  input  logic [2:0]    req_kind,
  input  logic [AW-1:0] req_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_err,
  output logic [N-1:0]  sh_datain,
  output logic [3:0]    sh_op,
  output logic [1:0]    sh_s,
  input  logic [N-1:0]  sh_dataout
);

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [2:0]    kind_q, kind_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] load_amt;
  logic [1:0]    step_s;
  logic          kind_ok;

`ifdef BSC_ROT_REDUCE_EN
  localparam logic [AW-1:0] N_AMT     = AW'(N);
  localparam int            RED_ITERS = ((1 << AW) + N - 1) / N;

  // Unrolled compare/subtract chain so the reduction fits in the single LOAD cycle.
  always_comb begin
    load_amt = rem_q;
    if (kind_is_rot(kind_q)) begin
      for (int i = 0; i < RED_ITERS; i++) begin
        if (load_amt >= N_AMT) load_amt = load_amt - N_AMT;
      end
    end else if (load_amt >= N_AMT) begin
      load_amt = N_AMT;
    end
  end
`else
  assign load_amt = rem_q;
`endif

  assign kind_ok = kind_defined(kind_q);
  assign step_s  = (rem_q > AW'(3)) ? 2'd3 : rem_q[1:0];

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    kind_d    = kind_q;
    rem_d     = rem_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    sh_op     = OP_HOLD;
    sh_s      = 2'd0;
    sh_datain = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst_n;
        if (req_valid && req_ready) begin
          data_d  = req_data;
          kind_d  = req_kind;
          rem_d   = req_amt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_op     = OP_LOAD;
        sh_datain = data_q;
        rem_d     = load_amt;
        state_d   = (load_amt == '0 || !kind_ok) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        sh_op = kind_to_op(kind_q);
        sh_s  = step_s;
        rem_d = rem_q - {{(AW-2){1'b0}}, step_s};
        if (rem_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        // Shifter sits in HOLD here, so its registered output is stable for the consumer.
        rsp_valid = 1'b1;
        rsp_data  = sh_dataout;
        rsp_err   = !kind_ok;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      kind_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
    end
  end

endmodule
